// File: rtl/cla_nibble_sequencer_pkg.sv
// Shared types and helpers for the nibble-serial CLA add/subtract sequencer.
//   state_t  : controller states (IDLE, RUN, DONE)
//   NIBBLE_W : width of the time-shared carry-lookahead adder slice
//   ovf_f    : two's-complement overflow from operand/result sign bits
package cla_seq_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Overflow when both operands share a sign and the result sign differs.
  // b_msb is the sign of the effective (possibly inverted) B operand.
  function automatic logic ovf_f(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/cla_nibble_sequencer_if.sv
// Request/response bundle between a requester and the nibble sequencer.
//   in_valid/in_ready    : operation handshake carrying a, b, cin, op_sub
//   out_valid/out_ready  : result handshake carrying sum, cout, overflow
//   master modport       : requester side; slave modport : sequencer side
interface cla_nibble_sequencer_if #(
  parameter int unsigned WIDTH = 32
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, op_sub, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, op_sub, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );

endinterface

// File: rtl/cla_nibble_sequencer_cla4.sv
// 4-bit carry-lookahead adder slice.
//   a, b : nibble operands   cin  : carry in
//   sum  : nibble sum        cout : carry out of bit 3
module CLA_4bit
  import cla_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;
  logic [NIBBLE_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry expanded directly from generate/propagate terms and cin.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[NIBBLE_W-1:0];
  assign cout = c[NIBBLE_W];

endmodule

// File: rtl/cla_nibble_sequencer.sv
// WIDTH-bit add/subtract computed one nibble per clock, LSB first, through a
// single shared 4-bit CLA slice.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of cla_nibble_sequencer_if (operands in, result out)
// Latency from accept edge to out_valid is WIDTH/4 cycles.
module cla_nibble_sequencer
  import cla_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  cla_nibble_sequencer_if.slave  bus
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < 8)) begin : g_width_check
    $error("cla_nibble_sequencer: WIDTH must be a multiple of 4 and at least 8");
  end

  state_t           state;
  logic [WIDTH-1:0] a_w;
  logic [WIDTH-1:0] b_w;
  logic             carry_w;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] work_sum;

  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             overflow_r;

  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] nib_sum;
  logic                nib_cout;
  logic [WIDTH-1:0]    work_next;

  // Operand nibble select for the current step.
  assign nib_a = a_w[NIBBLE_W*int'(idx) +: NIBBLE_W];
  assign nib_b = b_w[NIBBLE_W*int'(idx) +: NIBBLE_W];

  CLA_4bit u_cla (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_w),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // Partial sum with the current nibble merged in; on the last step this is
  // exactly {nib_sum, work_sum[WIDTH-5:0]}.
  always_comb begin
    work_next = work_sum;
    work_next[NIBBLE_W*int'(idx) +: NIBBLE_W] = nib_sum;
  end

  // Controller and datapath registers; all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      a_w         <= '0;
      b_w         <= '0;
      carry_w     <= 1'b0;
      idx         <= '0;
      work_sum    <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            // Subtract as A + ~B + 1; cin is ignored in that case.
            a_w        <= bus.a;
            b_w        <= bus.op_sub ? ~bus.b : bus.b;
            carry_w    <= bus.op_sub ? 1'b1 : bus.cin;
            idx        <= '0;
            in_ready_r <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          work_sum <= work_next;
          carry_w  <= nib_cout;
          if (idx == LAST_IDX) begin
            sum_r       <= work_next;
            cout_r      <= nib_cout;
            overflow_r  <= ovf_f(a_w[WIDTH-1], b_w[WIDTH-1], nib_sum[NIBBLE_W-1]);
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.sum       = sum_r;
  assign bus.cout      = cout_r;
  assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Self-checking bench for cla_nibble_sequencer (WIDTH=32): directed corner
// cases, backpressure, mid-operation reset and randomized add/subtract
// against an arithmetic reference model.
module tb_cla_nibble_sequencer;

  localparam int unsigned WIDTH   = 32;
  localparam int          LATENCY = 8;
  localparam longint      SMAX    = 64'sd2147483647;
  localparam longint      SMIN    = -64'sd2147483648;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_pass   = 0;

  cla_nibble_sequencer_if #(.WIDTH(WIDTH)) bus ();

  cla_nibble_sequencer #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: plain integer arithmetic, signed overflow from true range.
  task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic mc,
                       input logic ms, output logic [31:0] es, output logic ec,
                       output logic eo);
    logic [32:0] t;
    longint      sr;
    if (ms) begin
      es = ma - mb;
      ec = (ma >= mb);
      sr = longint'($signed(ma)) - longint'($signed(mb));
    end else begin
      t  = 33'(ma) + 33'(mb) + 33'(mc);
      es = t[31:0];
      ec = t[32];
      sr = longint'($signed(ma)) + longint'($signed(mb)) + longint'(mc);
    end
    eo = (sr > SMAX) || (sr < SMIN);
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc,
                       input logic ts);
    int n = 0;
    while (!bus.in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) check("accept_timeout", 64'(bus.in_ready), 64'(1));
    bus.in_valid = 1'b1;
    bus.a        = ta;
    bus.b        = tb_v;
    bus.cin      = tc;
    bus.op_sub   = ts;
    @(posedge clk);
    @(negedge clk);
    // Scramble operands after accept; they must have no effect.
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.cin      = 1'($urandom);
    bus.op_sub   = 1'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                              input logic tc, input logic ts, input int lat);
    logic [31:0] es;
    logic        ec;
    logic        eo;
    model(ta, tb_v, tc, ts, es, ec, eo);
    check({tag, "_lat"}, 64'(lat), 64'(LATENCY));
    check({tag, "_sum"}, 64'(bus.sum), 64'(es));
    check({tag, "_cout"}, 64'(bus.cout), 64'(ec));
    check({tag, "_ovf"}, 64'(bus.overflow), 64'(eo));
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(0));
  endtask

  task automatic release_result(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_out_valid_drop"}, 64'(bus.out_valid), 64'(0));
    check({tag, "_in_ready_back"}, 64'(bus.in_ready), 64'(1));
  endtask

  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic tc, input logic ts);
    int lat;
    issue(ta, tb_v, tc, ts);
    wait_done(lat);
    check_result(tag, ta, tb_v, tc, ts, lat);
    release_result(tag);
  endtask

  initial begin
    int          lat;
    logic [31:0] held_sum;
    logic        held_cout;
    logic        held_ovf;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    logic        rs;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.op_sub    = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_sum", 64'(bus.sum), 64'(0));
    check("rst_cout", 64'(bus.cout), 64'(0));
    check("rst_ovf", 64'(bus.overflow), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Directed corner cases.
    run_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    check("add_wrap_sum_const", 64'(bus.sum), 64'h0);
    run_op("sub_neg", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
    check("sub_neg_sum_const", 64'(bus.sum), 64'hFFFF_FFFE);
    run_op("sub_pos", 32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1);
    check("sub_pos_cout_const", 64'(bus.cout), 64'(1));
    run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    check("add_ovf_const", 64'(bus.overflow), 64'(1));
    run_op("add_cin", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
    check("add_cin_sum_const", 64'(bus.sum), 64'h2345_678A);
    run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);

    // Backpressure: hold result with new operands waiting.
    issue(32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 1'b0);
    wait_done(lat);
    check_result("bp_first", 32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 1'b0, lat);
    held_sum  = bus.sum;
    held_cout = bus.cout;
    held_ovf  = bus.overflow;
    bus.in_valid = 1'b1;
    bus.a        = 32'h4000_0000;
    bus.b        = 32'h4000_0000;
    bus.cin      = 1'b0;
    bus.op_sub   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 64'(bus.out_valid), 64'(1));
      check("bp_in_ready", 64'(bus.in_ready), 64'(0));
      check("bp_sum_stable", 64'(bus.sum), 64'(held_sum));
      check("bp_cout_stable", 64'(bus.cout), 64'(held_cout));
      check("bp_ovf_stable", 64'(bus.overflow), 64'(held_ovf));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_idle_in_ready", 64'(bus.in_ready), 64'(1));
    check("bp_idle_out_valid", 64'(bus.out_valid), 64'(0));
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    wait_done(lat);
    check_result("bp_second", 32'h4000_0000, 32'h4000_0000, 1'b0, 1'b0, lat);
    release_result("bp_second");

    // Reset while idx == 3 in RUN; previous result is nonzero.
    run_op("pre_rst", 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    check("midrst_sum", 64'(bus.sum), 64'(0));
    check("midrst_cout", 64'(bus.cout), 64'(0));
    check("midrst_ovf", 64'(bus.overflow), 64'(0));
    check("midrst_in_ready", 64'(bus.in_ready), 64'(1));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("post_rst", 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0);
    check("post_rst_sum_const", 64'(bus.sum), 64'h2);

    // Randomized operations.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom);
      rs = 1'($urandom);
      if (i % 6 == 0) rb = ~ra;
      if (i % 6 == 1) rb = ra;
      run_op("rand", ra, rb, rc, rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cla_nibble_sequencer.md
# cla_nibble_sequencer

Multi-cycle wide adder/subtractor controller that time-shares a single 4-bit carry-lookahead nibble adder across a WIDTH-bit operation, one nibble per clock, LSB first. It sits between an issuing requester (ALU/execute stage) and the nibble adder, accepting operands over a valid/ready handshake and returning sum, carry-out and signed overflow over a second valid/ready handshake. It trades latency for area where a full-width adder is not justified.

## Interface

- WIDTH, 32: operand width in bits; must be a multiple of 4 and at least 8.
- NIBBLES, WIDTH/4: derived local parameter; number of RUN cycles.
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  requester presents an operation.
- in_ready  output  1  block can accept; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for add; ignored when op_sub=1.
- op_sub  input  1  1 = A − B (B inverted, carry-in forced to 1).
- out_valid  output  1  result available; high only in DONE.
- out_ready  input  1  consumer takes result.
- sum  output  WIDTH  registered result.
- cout  output  1  carry out of bit WIDTH−1 (for subtract, 1 = no borrow).
- overflow  output  1  signed overflow of the operation.

## Operation

- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid && in_ready: latch a_w=a, b_w=(op_sub ? ~b : b), carry_w=(op_sub ? 1 : cin), clear idx; go to RUN.
- RUN: the nibble adder sees a_w[4·idx+:4], b_w[4·idx+:4] and carry_w. Each cycle, write its 4-bit sum into work_sum[4·idx+:4], update carry_w with its carry-out, and increment idx.
- On the cycle with idx == NIBBLES−1, the final nibble is computed and the outputs are loaded as follows:
  - sum = {nibble sum, work_sum[WIDTH−5:0]}
  - cout = nibble carry-out
  - overflow = (a_w[MSB] == b_w[MSB]) && (sum[MSB] != a_w[MSB]), computed on the effective B
  - The state then goes to DONE.
- DONE: out_valid=1; sum/cout/overflow held stable. On out_ready, go to IDLE.
- Inputs a, b, cin and op_sub are sampled only at the accepting edge. Changes at any other time have no effect.
- in_ready is low in RUN and DONE. There is no accept in the same cycle as an out_ready handshake.
- Outputs sum/cout/overflow are registered separately from work_sum. They keep the last completed result until the next DONE load, so they are never partial.
- The counter idx is log2(NIBBLES) bits wide (minimum 1) and never wraps past NIBBLES−1.

## Timing

- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, overflow=0, idx=0, work registers=0.
- Accept at edge E0. The RUN edges E1..E_NIBBLES process nibbles 0..NIBBLES−1, and out_valid rises after edge E_NIBBLES. Latency is NIBBLES cycles from accept to out_valid (8 for WIDTH=32).
- Minimum issue interval is NIBBLES+2 cycles when out_ready is tied high.
- Backpressure: out_valid stays high indefinitely while out_ready=0, with outputs unchanged.
- in_valid held during RUN/DONE is not accepted until the block has returned to IDLE.
- Reset asserted mid-RUN or in DONE: the operation is aborted immediately and no result is delivered. All outputs return to their reset values asynchronously.

## Structure

- Package cla_seq_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - localparam NIBBLE_W=4;
  - a helper function for the overflow expression.
- One sub-module: a single instance of the team's existing 4-bit carry-lookahead adder (CLA_4bit), driven by the mux-selected nibbles and carry_w. There is no other datapath.
- Elaboration-time assertion: WIDTH % 4 == 0 and WIDTH ≥ 8.

## Test plan

- WIDTH=32, add a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, overflow=0; out_valid rises exactly 8 cycles after the accept edge.
- Sub a=0x00000005, b=0x00000007 -> sum=0xFFFFFFFE, cout=0, overflow=0. Sub a=0x00000007, b=0x00000005 -> sum=0x00000002, cout=1.
- Add a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, overflow=1, cout=0. Add a=0x12345678, b=0x11111111, cin=1 -> sum=0x2345678A.
- Hold out_ready=0 for 5 cycles in DONE with in_valid=1 and new operands -> out_valid and outputs are stable and in_ready=0. Then out_ready=1 for 1 cycle -> IDLE, new operands accepted on the next edge.
- Assert rst while idx=3 in RUN -> out_valid=0, sum=0, in_ready=1 immediately. After release, a fresh add 0x1+0x1 returns 0x2 with no stale carry.
